// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU datapath: opcodes, field positions, widths.
package cpu_pkg;
  localparam int DW  = 32;
  localparam int RAW = 5;
  localparam int OPW = 3;

  // Instruction field bit positions
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 29;
  localparam int RA0_MSB  = 28;
  localparam int RA0_LSB  = 24;
  localparam int RA1_MSB  = 23;
  localparam int RA1_LSB  = 19;
  localparam int RA2_MSB  = 18;
  localparam int RA2_LSB  = 14;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 0;

  typedef enum logic [OPW-1:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_XOR   = 3'd6,
    OP_SLT   = 3'd7
  } opcode_e;
endpackage

// File: rtl/exec_alu.sv
// Combinational 32-bit ALU; memory opcodes yield 0 since their result is unused.
module exec_alu
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] i_op,
  input  logic [DW-1:0]  i_a,
  input  logic [DW-1:0]  i_b,
  output logic [DW-1:0]  o_res
);
  // Select the operation; ADD/SUB wrap naturally at 32 bits
  always_comb begin
    o_res = '0;
    case (opcode_e'(i_op))
      OP_ADD:  o_res = i_a + i_b;
      OP_SUB:  o_res = i_a - i_b;
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_SLT:  o_res = ($signed(i_a) < $signed(i_b)) ? 32'd1 : 32'd0;
      default: o_res = '0;
    endcase
  end
endmodule

// File: rtl/decode_exec_mem.sv
// Decode / execute / memory slice: combinational decode, ALU, word-addressed
// data memory, and a registered write-back stage one cycle after valid.
module decode_exec_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   inst,
  input  logic            valid,
  input  logic [DW-1:0]   op_a,
  input  logic [DW-1:0]   op_b,
  input  logic [DW-1:0]   st_data,
  output logic [OPW-1:0]  opcode,
  output logic [RAW-1:0]  reg_addr_0,
  output logic [RAW-1:0]  reg_addr_1,
  output logic [RAW-1:0]  reg_addr_2,
  output logic [15:0]     addr,
  output logic [DW-1:0]   wb_data,
  output logic [RAW-1:0]  wb_addr,
  output logic            wb_en,
  output logic            out_valid
);
  logic [DW-1:0]  r_mem [DEPTH];
  logic [DW-1:0]  r_wb_data;
  logic [RAW-1:0] r_wb_addr;
  logic           r_wb_en;
  logic           r_out_valid;
  logic [DW-1:0]  w_alu;
  logic [AW-1:0]  w_idx;

  // Field extraction; addr and reg_addr_2 overlap on bits 15:14 by design
  assign opcode     = inst[OPC_MSB:OPC_LSB];
  assign reg_addr_0 = inst[RA0_MSB:RA0_LSB];
  assign reg_addr_1 = inst[RA1_MSB:RA1_LSB];
  assign reg_addr_2 = inst[RA2_MSB:RA2_LSB];
  assign addr       = inst[ADDR_MSB:ADDR_LSB];

  // Upper address bits are dropped so accesses wrap around the memory
  assign w_idx = addr[AW-1:0];

  exec_alu u_alu (
    .i_op  (opcode),
    .i_a   (op_a),
    .i_b   (op_b),
    .o_res (w_alu)
  );

  // Write-back stage and memory; reset clears everything and drops any valid op
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_data   <= '0;
      r_wb_addr   <= '0;
      r_wb_en     <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_out_valid <= valid;
      if (valid) begin
        r_wb_addr <= reg_addr_0;
        case (opcode_e'(opcode))
          OP_LOAD: begin
            r_wb_data <= r_mem[w_idx];
            r_wb_en   <= 1'b1;
          end
          OP_STORE: begin
            r_mem[w_idx] <= st_data;
            r_wb_en      <= 1'b0;
          end
          default: begin
            r_wb_data <= w_alu;
            r_wb_en   <= 1'b1;
          end
        endcase
      end else begin
        r_wb_en <= 1'b0;
      end
    end
  end

  assign wb_data   = r_wb_data;
  assign wb_addr   = r_wb_addr;
  assign wb_en     = r_wb_en;
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_decode_exec_mem.sv
// Self-checking bench: behavioural model + per-cycle compare, directed pins, random run.
module tb_decode_exec_mem;
  logic        clk = 0;
  logic        reset;
  logic [31:0] inst, op_a, op_b, st_data;
  logic        valid;
  logic [2:0]  opcode;
  logic [4:0]  reg_addr_0, reg_addr_1, reg_addr_2;
  logic [15:0] addr;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en, out_valid;

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 0;

  decode_exec_mem dut (
    .clk(clk), .reset(reset), .inst(inst), .valid(valid),
    .op_a(op_a), .op_b(op_b), .st_data(st_data),
    .opcode(opcode), .reg_addr_0(reg_addr_0), .reg_addr_1(reg_addr_1),
    .reg_addr_2(reg_addr_2), .addr(addr),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_en(wb_en), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_mem [256];
  logic [31:0] m_data;
  logic [4:0]  m_addr;
  logic        m_en, m_ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: apply the instruction semantics at each rising edge
  always @(posedge clk) begin
    int unsigned op, idx;
    logic [31:0] a, b, r;
    if (reset) begin
      m_data = 0; m_addr = 0; m_en = 0; m_ov = 0;
      for (int i = 0; i < 256; i++) m_mem[i] = 0;
    end else if (valid) begin
      op = inst[31:29];
      idx = inst[7:0];
      a = op_a; b = op_b;
      m_ov = 1;
      m_addr = inst[28:24];
      m_en = (op != 1);
      case (op)
        0: m_data = m_mem[idx];
        1: m_mem[idx] = st_data;
        2: m_data = a + b;
        3: m_data = a - b;
        4: m_data = a & b;
        5: m_data = a | b;
        6: m_data = a ^ b;
        default: begin
          r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          m_data = r;
        end
      endcase
    end else begin
      m_ov = 0; m_en = 0;
    end
  end

  // Compare process: outputs against the model every cycle once reset has been seen
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmp_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("cmp_wb_en", {31'd0, wb_en}, {31'd0, m_en});
      chk("cmp_wb_addr", {27'd0, wb_addr}, {27'd0, m_addr});
      chk("cmp_wb_data", wb_data, m_data);
    end
  end

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] ra0,
                                     input logic [4:0] ra1, input logic [15:0] ad);
    return {op, ra0, ra1, 3'b000, ad};
  endfunction

  // Drive one cycle's inputs away from the edge, then wait past the next rising edge
  task automatic cyc(input logic r, input logic v, input logic [31:0] in,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd);
    @(negedge clk);
    #2;
    reset = r; valid = v; inst = in; op_a = a; op_b = b; st_data = sd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; valid = 0; op_a = 0; op_b = 0; st_data = 0;
    // Decode needs no clock
    inst = 32'h4A8C_1234;
    #1;
    chk("dec_opcode", {29'd0, opcode}, 32'd2);
    chk("dec_ra0", {27'd0, reg_addr_0}, 32'd10);
    chk("dec_ra1", {27'd0, reg_addr_1}, 32'd17);
    chk("dec_ra2", {27'd0, reg_addr_2}, 32'd16);
    chk("dec_addr", {16'd0, addr}, 32'h1234);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk_on = 1;
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_en", {31'd0, wb_en}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);

    cyc(0, 1, mk(3'd2, 5'd4, 5'd1, 16'h0), 32'hFFFF_FFFF, 32'd1, 0);
    chk("add_wrap", wb_data, 32'h0);
    chk("add_en", {31'd0, wb_en}, 1);
    chk("add_ov", {31'd0, out_valid}, 1);
    chk("add_waddr", {27'd0, wb_addr}, 4);

    cyc(0, 1, mk(3'd3, 5'd6, 5'd1, 16'h0), 32'd5, 32'd7, 0);
    chk("sub_neg", wb_data, 32'hFFFF_FFFE);

    cyc(0, 1, mk(3'd7, 5'd6, 5'd1, 16'h0), 32'hFFFF_FFFF, 32'd1, 0);
    chk("slt_signed", wb_data, 32'd1);

    cyc(0, 1, mk(3'd1, 5'd9, 5'd1, 16'h0005), 0, 0, 32'hDEAD_BEEF);
    chk("store_en", {31'd0, wb_en}, 0);
    chk("store_ov", {31'd0, out_valid}, 1);

    cyc(0, 1, mk(3'd0, 5'd12, 5'd1, 16'h0105), 0, 0, 0);
    chk("load_wrap", wb_data, 32'hDEAD_BEEF);
    chk("load_waddr", {27'd0, wb_addr}, 12);
    chk("load_en", {31'd0, wb_en}, 1);

    cyc(0, 0, mk(3'd2, 5'd1, 5'd1, 16'h0), 1, 1, 0);
    chk("idle_ov", {31'd0, out_valid}, 0);
    chk("idle_en", {31'd0, wb_en}, 0);
    chk("idle_hold", wb_data, 32'hDEAD_BEEF);

    // Reset clears memory and discards a concurrent store
    cyc(0, 1, mk(3'd1, 5'd2, 5'd1, 16'h0003), 0, 0, 32'h1234);
    cyc(1, 1, mk(3'd1, 5'd2, 5'd1, 16'h0007), 0, 0, 32'h5555);
    chk("rst2_data", wb_data, 0);
    chk("rst2_en", {31'd0, wb_en}, 0);
    chk("rst2_ov", {31'd0, out_valid}, 0);
    chk("rst2_addr", {27'd0, wb_addr}, 0);
    cyc(0, 1, mk(3'd0, 5'd3, 5'd1, 16'h0003), 0, 0, 0);
    chk("rst_cleared", wb_data, 0);
    cyc(0, 1, mk(3'd0, 5'd3, 5'd1, 16'h0007), 0, 0, 0);
    chk("rst_no_store", wb_data, 0);

    // Random run: small index range so loads hit earlier stores
    for (int k = 0; k < 400; k++) begin
      logic [15:0] ad;
      logic [31:0] in;
      ad = {8'($urandom), 4'd0, 4'($urandom)};
      in = mk(3'($urandom), 5'($urandom), 5'($urandom), ad);
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), in,
          ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
          ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom, $urandom);
      chk("rnd_dec_op", {29'd0, opcode}, {29'd0, in[31:29]});
      chk("rnd_dec_addr", {16'd0, addr}, {16'd0, in[15:0]});
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
